// File: rtl/exp_pkg.sv
// Shared types and default parameters for the exponential-engine arbiter.
package exp_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4,
    ABORT   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/exp_engine_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above
// rr_ptr, searching upward with wrap.
module rr_pick
  import exp_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any
);

  localparam int PTR_W = $clog2(N_REQ);

  int idx;

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx]) begin
        any       = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/exp_engine_arbiter.sv
// Round-robin scheduler sharing one exponential-series engine among N_REQ
// requesters, with watchdog abort of a hung engine.
//
// state   | meaning
// IDLE    | waiting for any request; grant latched on exit
// START   | eng_s high for one cycle; engine starts on its fall
// RUN     | waiting for eng_done; watchdog counting
// CAPTURE | engine result register now valid; sample into res_q
// RESP    | one-cycle ack to the granted requester; pointer advances
// ABORT   | watchdog expired; one-cycle engine reset
module exp_engine_arbiter
  import exp_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    eng_s,
  output logic [DATA_W-1:0]       eng_x,
  output logic                    eng_rst,
  input  logic                    eng_done,
  input  logic [DATA_W-1:0]       eng_result
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  gnt_q, gnt_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              err_q, err_d;

  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .grant_idx(pick_idx),
    .any      (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      op_q     <= '0;
      res_q    <= '0;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      res_q    <= res_d;
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    res_d    = res_q;
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;

    ack       = '0;
    resp_data = '0;
    resp_err  = 1'b0;
    busy      = (state_q != IDLE);
    eng_s     = (state_q == START);
    eng_rst   = (state_q == ABORT);
    eng_x     = op_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d    = pick_idx;
          op_d     = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          wd_cnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        wd_cnt_d = '0;
        state_d  = RUN;
      end
      RUN: begin
        // Completion wins over a timeout landing in the same cycle.
        if (eng_done) begin
          state_d = CAPTURE;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = ABORT;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      CAPTURE: begin
        res_d   = eng_result;
        err_d   = 1'b0;
        state_d = RESP;
      end
      ABORT: begin
        res_d   = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        ack[gnt_q] = 1'b1;
        resp_data  = res_q;
        resp_err   = err_q;
        rr_ptr_d   = (gnt_q == PTR_LAST) ? '0 : gnt_q + PTR_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exp_engine_arbiter.sv
// Directed bench for exp_engine_arbiter: table of jobs plus hand-written
// sequences for operand freeze, stray done, timeout and mid-run reset.
module tb_exp_engine_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] ack;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          busy;
  logic          eng_s;
  logic [DW-1:0] eng_x;
  logic          eng_rst;
  logic          eng_done;
  logic [DW-1:0] eng_result;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] opnd [NR];

  typedef struct {
    logic [NR-1:0] rq;
    int            g;
    logic [NR-1:0] exp_ack;
    int            dly;
    logic [DW-1:0] res;
    logic          drop;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  exp_engine_arbiter #(
    .N_REQ  (NR),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .busy      (busy),
    .eng_s     (eng_s),
    .eng_x     (eng_x),
    .eng_rst   (eng_rst),
    .eng_done  (eng_done),
    .eng_result(eng_result)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = opnd[i];
  endtask

  // Waits for START, checks the single-cycle start, then lets the engine
  // finish dly cycles after the first RUN cycle; ack lands two cycles later.
  task automatic do_job(input int g, input logic [NR-1:0] exp_ack, input int dly,
                        input logic [DW-1:0] res, input logic drop);
    int n;
    n = 0;
    while (eng_s !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("grant_latency", 64'(n), 64'd1);
    chk("start_seen", 64'(eng_s), 64'd1);
    chk("eng_x", 64'(eng_x), 64'(opnd[g]));
    tick();
    chk("start_one_cycle", 64'(eng_s), 64'd0);
    chk("busy_run", 64'(busy), 64'd1);
    repeat (dly) tick();
    eng_done   = 1'b1;
    eng_result = 16'hDEAD;
    tick();
    eng_done   = 1'b0;
    eng_result = res;
    chk("capture_no_ack", 64'(ack), 64'd0);
    tick();
    chk("ack", 64'(ack), 64'(exp_ack));
    chk("resp_data", 64'(resp_data), 64'(res));
    chk("resp_err", 64'(resp_err), 64'd0);
    if (drop) req[g] = 1'b0;
    tick();
    chk("ack_one_cycle", 64'(ack), 64'd0);
    chk("idle_gap", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    opnd[0] = 16'h0A00;
    opnd[1] = 16'h0100;
    opnd[2] = 16'h0C33;
    opnd[3] = 16'h0D44;

    // Pointer trace: fairness 0,1,2,3,0 (ptr->1); single req1 (ptr->2);
    // req2 (ptr->3); 1001 serves 3 then 0 (ptr->1).
    tbl[0] = '{4'b1111, 0, 4'b0001, 3, 16'h1111, 1'b0};
    tbl[1] = '{4'b1111, 1, 4'b0010, 1, 16'h2222, 1'b0};
    tbl[2] = '{4'b1111, 2, 4'b0100, 0, 16'h3333, 1'b0};
    tbl[3] = '{4'b1111, 3, 4'b1000, 2, 16'h4444, 1'b0};
    tbl[4] = '{4'b1111, 0, 4'b0001, 4, 16'h5555, 1'b0};
    tbl[5] = '{4'b0010, 1, 4'b0010, 5, 16'h02B7, 1'b1};
    tbl[6] = '{4'b0100, 2, 4'b0100, 2, 16'h0ABC, 1'b1};
    tbl[7] = '{4'b1001, 3, 4'b1000, 1, 16'h0F0F, 1'b1};
    tbl[8] = '{4'b0001, 0, 4'b0001, 3, 16'h0123, 1'b1};

    rst        = 1'b1;
    req        = '0;
    eng_done   = 1'b0;
    eng_result = '0;
    set_data();
    repeat (2) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_eng_s", 64'(eng_s), 64'd0);
    chk("rst_eng_x", 64'(eng_x), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_ack", 64'(ack), 64'd0);
    chk("idle_resp_data", 64'(resp_data), 64'd0);
    chk("idle_resp_err", 64'(resp_err), 64'd0);
    chk("idle_eng_rst", 64'(eng_rst), 64'd0);

    for (int v = 0; v < 9; v++) begin
      req = tbl[v].rq;
      do_job(tbl[v].g, tbl[v].exp_ack, tbl[v].dly, tbl[v].res, tbl[v].drop);
    end

    // Operand freeze and request drop mid-run (ptr=1, requester 1 wins).
    req = 4'b0010;
    n = 0;
    while (eng_s !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("drop_start", 64'(eng_s), 64'd1);
    tick();
    opnd[1] = 16'hFFFF;
    set_data();
    req = 4'b0000;
    tick();
    chk("op_frozen", 64'(eng_x), 64'h0100);
    eng_done = 1'b1;
    tick();
    eng_done   = 1'b0;
    eng_result = 16'h0777;
    tick();
    chk("drop_ack", 64'(ack), 64'b0010);
    chk("drop_resp", 64'(resp_data), 64'h0777);
    tick();
    chk("drop_idle", 64'(busy), 64'd0);
    opnd[1] = 16'h0100;
    set_data();

    // Stray done in IDLE must not start anything.
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_busy", 64'(busy), 64'd0);
      chk("stray_ack", 64'(ack), 64'd0);
    end
    tick();
    chk("stray_eng_s", 64'(eng_s), 64'd0);

    // Timeout (ptr=2, requester 2). START at s, RUN s+1..s+16 with wd_cnt
    // 0..15; wd_cnt==15 in s+16 sends ABORT (eng_rst) to s+17.
    eng_result = 16'h1234;
    req = 4'b0100;
    n = 0;
    while (eng_s !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("to_start", 64'(eng_s), 64'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (eng_rst !== 1'b1 && n < 40);
    chk("to_abort_cycle", 64'(n), 64'd17);
    chk("to_abort_no_ack", 64'(ack), 64'd0);
    tick();
    chk("to_ack", 64'(ack), 64'b0100);
    chk("to_err", 64'(resp_err), 64'd1);
    chk("to_data", 64'(resp_data), 64'd0);
    chk("to_rst_pulse", 64'(eng_rst), 64'd0);
    req = 4'b0000;
    tick();
    chk("to_busy_fall", 64'(busy), 64'd0);

    // Reset mid-run (ptr=3, requester 3 in RUN).
    req = 4'b1000;
    n = 0;
    while (eng_s !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_eng_s", 64'(eng_s), 64'd0);
    chk("mid_rst_eng_x", 64'(eng_x), 64'd0);
    chk("mid_rst_ack", 64'(ack), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_ack", 64'(ack), 64'd0);
    end
    rst = 1'b0;
    req = 4'b1001;
    do_job(0, 4'b0001, 2, 16'h0456, 1'b1);
    do_job(3, 4'b1000, 1, 16'h0789, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
